// File: rtl/riscv_multicycle.sv
// Multicycle RV32I/RV32E subset core with one shared memory port.
// States: FETCH read IR | DECODE read regs, branch/jal target | MEMADR effective address
//   MEMREAD load wait | MEMWB load writeback | MEMWRITE store wait | EXECR/EXECI ALU op
//   ALUWB ALU writeback | BRANCH resolve | JAL link+jump | HALT unsupported instruction
module riscv_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAdr,
  output logic [31:0] MemWData,
  input  logic [31:0] MemRData,
  input  logic        MemReady,
  output logic        Retired,
  output logic        Illegal,
  output logic [31:0] PC
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, HALT
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam int         IDXW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_L   = 6'(NREGS);

  state_t      state_q, state_d, dispatch;
  logic [31:0] pc_q, pc_d, old_pc_q, old_pc_d, ir_q, ir_d;
  logic [31:0] a_q, a_d, b_q, b_d, alu_q, alu_d, data_q, data_d;
  logic [31:0] regs_q [NREGS];

  logic        rf_we;
  logic [31:0] rf_wd;

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;
  logic        rs1_ok, rs2_ok, rd_ok, alu_f3_ok;
  logic [31:0] rs1_val, rs2_val;
  logic [31:0] alu_b, alu_res, diff;
  logic        alu_sub, taken;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];

  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // Indices beyond the implemented register count (RV32E) are decode faults.
  assign rs1_ok = ({1'b0, rs1} < NREGS_L);
  assign rs2_ok = ({1'b0, rs2} < NREGS_L);
  assign rd_ok  = ({1'b0, rd}  < NREGS_L);

  assign rs1_val = (rs1 == 5'd0 || !rs1_ok) ? '0 : regs_q[rs1[IDXW-1:0]];
  assign rs2_val = (rs2 == 5'd0 || !rs2_ok) ? '0 : regs_q[rs2[IDXW-1:0]];

  assign alu_f3_ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);

  always_comb begin
    dispatch = HALT;
    case (opcode)
      OP_LOAD:   if (f3 == 3'b010 && rs1_ok && rd_ok) dispatch = MEMADR;
      OP_STORE:  if (f3 == 3'b010 && rs1_ok && rs2_ok) dispatch = MEMADR;
      OP_REG:    if (((f7 == 7'b0000000 && alu_f3_ok) || (f7 == 7'b0100000 && f3 == 3'b000))
                     && rs1_ok && rs2_ok && rd_ok) dispatch = EXECR;
      OP_IMM:    if (alu_f3_ok && rs1_ok && rd_ok) dispatch = EXECI;
      OP_BRANCH: if ((f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100) && rs1_ok && rs2_ok)
                   dispatch = BRANCH;
      OP_JAL:    if (rd_ok) dispatch = JAL;
      default:   dispatch = HALT;
    endcase
  end

  always_comb begin
    alu_res = '0;
    alu_b   = (state_q == EXECI) ? imm_i : b_q;
    alu_sub = (state_q == EXECR) && f7[5];
    case (f3)
      3'b000:  alu_res = alu_sub ? a_q - alu_b : a_q + alu_b;
      3'b111:  alu_res = a_q & alu_b;
      3'b110:  alu_res = a_q | alu_b;
      3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(alu_b)};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    diff  = a_q - b_q;
    taken = 1'b0;
    case (f3)
      3'b000:  taken = (diff == 32'd0);
      3'b001:  taken = (diff != 32'd0);
      3'b100:  taken = $signed(a_q) < $signed(b_q);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    old_pc_d = old_pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    data_d   = data_q;
    MemReq   = 1'b0;
    MemWE    = 1'b0;
    MemAdr   = alu_q;
    MemWData = b_q;
    Retired  = 1'b0;
    Illegal  = 1'b0;
    rf_we    = 1'b0;
    rf_wd    = alu_q;
    case (state_q)
      FETCH: begin
        MemReq = 1'b1;
        MemAdr = pc_q;
        if (MemReady) begin
          ir_d     = MemRData;
          old_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = DECODE;
        end
      end
      DECODE: begin
        a_d     = rs1_val;
        b_d     = rs2_val;
        alu_d   = old_pc_q + ((opcode == OP_JAL) ? imm_j : imm_b);
        state_d = dispatch;
      end
      MEMADR: begin
        alu_d   = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
        state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        MemReq = 1'b1;
        if (MemReady) begin
          data_d  = MemRData;
          state_d = MEMWB;
        end
      end
      MEMWB: begin
        rf_we   = 1'b1;
        rf_wd   = data_q;
        Retired = 1'b1;
        state_d = FETCH;
      end
      MEMWRITE: begin
        MemReq = 1'b1;
        MemWE  = 1'b1;
        if (MemReady) begin
          Retired = 1'b1;
          state_d = FETCH;
        end
      end
      EXECR, EXECI: begin
        alu_d   = alu_res;
        state_d = ALUWB;
      end
      ALUWB: begin
        rf_we   = 1'b1;
        Retired = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        if (taken) pc_d = alu_q;
        Retired = 1'b1;
        state_d = FETCH;
      end
      JAL: begin
        rf_we   = 1'b1;
        rf_wd   = pc_q;
        pc_d    = alu_q;
        Retired = 1'b1;
        state_d = FETCH;
      end
      HALT: Illegal = 1'b1;
      default: state_d = HALT;
    endcase
    // A reset cycle must not start a bus access or commit anything.
    if (reset) begin
      MemReq  = 1'b0;
      MemWE   = 1'b0;
      Retired = 1'b0;
      Illegal = 1'b0;
      rf_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      old_pc_q <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      data_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      old_pc_q <= old_pc_d;
      ir_q     <= ir_d;
      a_q      <= a_d;
      b_q      <= b_d;
      alu_q    <= alu_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (rf_we && rd != 5'd0) begin
      regs_q[rd[IDXW-1:0]] <= rf_wd;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_riscv_multicycle.sv
// Scoreboard bench: an ISA-level model predicts retirements and stores; a monitor checks them.
module tb_riscv_multicycle;

  localparam logic [31:0] RST = 32'h100;

  logic        clk, reset;
  logic        MemReq, MemWE, MemReady, Retired, Illegal;
  logic [31:0] MemAdr, MemWData, MemRData, PC;

  riscv_multicycle #(.RESET_PC(RST), .NREGS(32)) dut (
    .clk(clk), .reset(reset), .MemReq(MemReq), .MemWE(MemWE), .MemAdr(MemAdr),
    .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady),
    .Retired(Retired), .Illegal(Illegal), .PC(PC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int lat; logic [31:0] pc; } ret_t;
  typedef struct { logic [31:0] adr; logic [31:0] dat; } wr_t;

  ret_t        rq[$];
  wr_t         wq[$];
  logic [31:0] mem     [1024];
  logic [31:0] exp_mem [1024];
  logic [31:0] wp;
  int          checks = 0, errors = 0;
  int          stall_mode = 0;
  logic        mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [2:0] pick_alu(input int k);
    case (k)
      0: return 3'b000;
      1: return 3'b111;
      2: return 3'b110;
      default: return 3'b010;
    endcase
  endfunction
  function automatic logic [2:0] pick_br(input int k);
    case (k)
      0: return 3'b000;
      1: return 3'b001;
      default: return 3'b100;
    endcase
  endfunction

  task automatic put(input logic [31:0] w);
    mem[wp[11:2]] = w;
    wp = wp + 32'd4;
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    wp = RST;
  endtask

  // ---------------- reference model (ISA level) ----------------
  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic sub,
                                          input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'b000:  return sub ? x - y : x + y;
      3'b111:  return x & y;
      3'b110:  return x | y;
      default: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic model_run(output logic [31:0] halt_pc);
    logic [31:0] r [32];
    logic [31:0] pc, ir, nxt, val, adr, x, y, ii, is, ib, ij;
    logic [6:0]  op, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        legal, wr, tk, f3ok;
    int          lat;
    for (int i = 0; i < 32; i++) r[i] = '0;
    exp_mem = mem;
    pc = RST;
    halt_pc = 32'hFFFF_FFFF;
    for (int step = 0; step < 5000; step++) begin
      ir  = exp_mem[pc[11:2]];
      op  = ir[6:0];  rd = ir[11:7]; f3 = ir[14:12];
      rs1 = ir[19:15]; rs2 = ir[24:20]; f7 = ir[31:25];
      ii  = 32'($signed(ir[31:20]));
      is  = 32'($signed({ir[31:25], ir[11:7]}));
      ib  = 32'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
      ij  = 32'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));
      x = r[rs1]; y = r[rs2];
      f3ok = (f3 == 3'd0) || (f3 == 3'd7) || (f3 == 3'd6) || (f3 == 3'd2);
      legal = 1'b1; wr = 1'b0; val = '0; nxt = pc + 32'd4; lat = 4; tk = 1'b0;
      case (op)
        7'b0010011: if (f3ok) begin wr = 1'b1; val = ref_alu(f3, 1'b0, x, ii); end
                    else legal = 1'b0;
        7'b0110011: if ((f7 == 7'h00 && f3ok) || (f7 == 7'h20 && f3 == 3'd0)) begin
                      wr = 1'b1; val = ref_alu(f3, f7[5], x, y);
                    end else legal = 1'b0;
        7'b0000011: if (f3 == 3'd2) begin
                      adr = x + ii; wr = 1'b1; val = exp_mem[adr[11:2]]; lat = 5;
                    end else legal = 1'b0;
        7'b0100011: if (f3 == 3'd2) begin
                      adr = x + is; exp_mem[adr[11:2]] = y; wq.push_back('{adr, y});
                    end else legal = 1'b0;
        7'b1100011: begin
          lat = 3;
          case (f3)
            3'd0:    tk = (x == y);
            3'd1:    tk = (x != y);
            3'd4:    tk = ($signed(x) < $signed(y));
            default: legal = 1'b0;
          endcase
          if (tk) nxt = pc + ib;
        end
        7'b1101111: begin lat = 3; wr = 1'b1; val = pc + 32'd4; nxt = pc + ij; end
        default: legal = 1'b0;
      endcase
      if (!legal) begin
        halt_pc = pc + 32'd4;
        return;
      end
      if (wr && rd != 5'd0) r[rd] = val;
      rq.push_back('{lat, nxt});
      pc = nxt;
    end
  endtask

  // ---------------- memory responder ----------------
  int wcnt = 0;
  initial begin
    logic rdy;
    MemReady = 1'b0;
    MemRData = '0;
    forever begin
      @(posedge clk); #1;
      rdy = 1'b1;
      case (stall_mode)
        1: rdy = ($urandom_range(0, 3) != 0);
        2: if (MemReq && MemAdr != PC) begin
             if (wcnt < 2) begin rdy = 1'b0; wcnt++; end
             else wcnt = 0;
           end
        3: if (MemReq && !MemWE && MemAdr == 32'h400) rdy = 1'b0;
        default: rdy = 1'b1;
      endcase
      MemReady = rdy;
      MemRData = mem[MemAdr[11:2]];
    end
  end

  always @(negedge clk)
    if (!reset && MemReq && MemWE && MemReady) mem[MemAdr[11:2]] = MemWData;

  // ---------------- monitor ----------------
  initial begin
    int   cyc, stl;
    ret_t e;
    wr_t  w;
    cyc = 0; stl = 0;
    forever begin
      @(negedge clk);
      if (reset || !mon_en) begin cyc = 0; stl = 0; continue; end
      cyc++;
      if (MemReq && !MemReady) stl++;
      if (MemReq && MemWE && MemReady) begin
        if (wq.size() == 0) chk("store_unexpected", MemAdr, 32'hFFFF_FFFF);
        else begin
          w = wq.pop_front();
          chk("store_adr", MemAdr, w.adr);
          chk("store_data", MemWData, w.dat);
        end
      end
      if (Retired) begin
        if (rq.size() == 0) chk("retire_unexpected", PC, 32'hFFFF_FFFF);
        else begin
          e = rq.pop_front();
          chk("latency", 32'(cyc), 32'(e.lat + stl));
          @(posedge clk); #1;
          chk("retire_pc", PC, e.pc);
        end
        cyc = 0; stl = 0;
      end
    end
  end

  // ---------------- run one program image ----------------
  task automatic run_prog(input int mode);
    logic [31:0] hpc;
    logic        bad;
    int          n;
    rq.delete(); wq.delete();
    model_run(hpc);
    stall_mode = mode;
    wcnt = 0;
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", {29'b0, MemReq, Retired, Illegal}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("first_fetch_req", 32'(MemReq), 32'd1);
    chk("first_fetch_adr", MemAdr, RST);
    n = 0;
    while (!Illegal && n < 4000) begin @(negedge clk); n++; end
    chk("halted", 32'(Illegal), 32'd1);
    chk("halt_pc", PC, hpc);
    bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (MemReq || !Illegal || PC !== hpc) bad = 1'b1;
    end
    chk("halt_hold", 32'(bad), 32'd0);
    chk("retire_left", 32'(rq.size()), 32'd0);
    chk("store_left", 32'(wq.size()), 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad = 1'b1;
    chk("mem_image", 32'(bad), 32'd0);
    mon_en = 1'b0;
  endtask

  task automatic gen_random(input int n);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] off;
    int          k;
    clear_mem();
    for (int i = 0; i < 16; i++) mem[256 + i] = $urandom();
    for (int i = 0; i < n; i++) begin
      rd  = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) rs2 = rs1;
      off = 12'(32'h400 + 4 * $urandom_range(0, 15));
      case ($urandom_range(0, 9))
        3, 4: begin
          k = int'($urandom_range(0, 4));
          if (k == 4) put(enc_r(7'h20, rs2, rs1, 3'b000, rd));
          else        put(enc_r(7'h00, rs2, rs1, pick_alu(k), rd));
        end
        5: put(enc_s(off, rs2, 5'd0));
        6: put(enc_i(off, 5'd0, 3'b010, rd, 7'b0000011));
        7: put(enc_b(13'd8, rs2, rs1, pick_br(int'($urandom_range(0, 2)))));
        8: put(enc_j(21'd8, rd));
        default: put(enc_i(12'($urandom()), rs1, pick_alu(int'($urandom_range(0, 3))), rd,
                           7'b0010011));
      endcase
    end
    case ($urandom_range(0, 3))
      0: put(32'h0000_007F);
      1: put(enc_r(7'h20, 5'd2, 5'd1, 3'b111, 5'd3));
      2: put(enc_b(13'd8, 5'd2, 5'd1, 3'b010));
      default: put(enc_i(12'h001, 5'd1, 3'b001, 5'd3, 7'b0010011));
    endcase
    put(32'h0000_007F);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic found;
    int   n;
    reset = 1'b1;
    clear_mem();

    // addi x1,x0,5 then expose x1 through a store
    clear_mem();
    put(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put(enc_s(12'h400, 5'd1, 5'd0));
    put(32'h0000_007F);
    run_prog(0);

    // store/load round trip with two wait cycles on each data access
    clear_mem();
    put(enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put(enc_s(12'h008, 5'd1, 5'd0));
    put(enc_i(12'h008, 5'd0, 3'b010, 5'd2, 7'b0000011));
    put(enc_s(12'h404, 5'd2, 5'd0));
    put(32'h0000_007F);
    run_prog(2);

    // beq taken over three words, then bne not taken
    clear_mem();
    put(enc_i(12'd3, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put(enc_i(12'd3, 5'd0, 3'b000, 5'd2, 7'b0010011));
    put(enc_b(13'd16, 5'd2, 5'd1, 3'b000));
    put(32'h0000_007F); put(32'h0000_007F); put(32'h0000_007F);
    put(enc_b(13'd16, 5'd2, 5'd1, 3'b001));
    put(32'h0000_007F);
    run_prog(1);

    // signed blt taken, forward jal, backward jal with link
    clear_mem();
    put(enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011));
    put(enc_i(12'd1, 5'd0, 3'b000, 5'd2, 7'b0010011));
    put(enc_b(13'd8, 5'd2, 5'd1, 3'b100));
    put(32'h0000_007F);
    put(enc_j(21'd12, 5'd0));
    put(enc_s(12'h408, 5'd5, 5'd0));
    put(32'h0000_007F);
    put(enc_j(21'h1F_FFF8, 5'd5));
    run_prog(1);

    // x0 stays zero
    clear_mem();
    mem[259] = 32'hFFFF_FFFF;
    put(enc_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011));
    put(enc_s(12'h40C, 5'd0, 5'd0));
    put(32'h0000_007F);
    run_prog(0);

    for (int t = 0; t < 4; t++) begin
      gen_random(60);
      run_prog(1);
    end

    // reset while a load waits on memory
    clear_mem();
    mem[256] = 32'h55;
    mem[257] = 32'hDEAD;
    put(enc_i(12'd9, 5'd0, 3'b000, 5'd3, 7'b0010011));
    put(enc_i(12'h400, 5'd0, 3'b010, 5'd3, 7'b0000011));
    put(enc_s(12'h404, 5'd3, 5'd0));
    put(32'h0000_007F);
    mon_en = 1'b0;
    stall_mode = 3;
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    found = 1'b0; n = 0;
    while (!found && n < 100) begin
      @(negedge clk); n++;
      if (MemReq && !MemWE && MemAdr == 32'h400) found = 1'b1;
    end
    chk("abort_reach_load", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; reset = 1'b1;
    @(negedge clk);
    chk("abort_memreq", 32'(MemReq), 32'd0);
    @(posedge clk); #1; reset = 1'b0; stall_mode = 0;
    @(negedge clk);
    chk("abort_refetch_adr", MemAdr, RST);
    chk("abort_refetch_pc", PC, RST);
    chk("abort_no_store", mem[257], 32'hDEAD);
    run_prog(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_multicycle.md
RISCV_MULTICYCLE -- requirements
Module: riscv_multicycle

Interface
- REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
- REQ-002 SHALL provide parameter NREGS, default 32: register count; 32 for RV32I, 16 for RV32E.
- REQ-003 SHALL provide clk  input  1: sole clock, all state updates on rising edge.
- REQ-004 SHALL provide reset  input  1: synchronous, active-high reset.
- REQ-005 SHALL provide MemReq  output  1: memory access requested this cycle.
- REQ-006 SHALL provide MemWE  output  1: access is a word write.
- REQ-007 SHALL provide MemAdr  output  32: byte address of the access.
- REQ-008 SHALL provide MemWData  output  32: store data.
- REQ-009 SHALL provide MemRData  input  32: read data, valid when MemReady is high.
- REQ-010 SHALL provide MemReady  input  1: access completes in any cycle where MemReq and MemReady are both high.
- REQ-011 SHALL provide Retired  output  1: one-cycle pulse on the final cycle of each instruction.
- REQ-012 SHALL provide Illegal  output  1: core halted on an unsupported instruction.
- REQ-013 SHALL provide PC  output  32: architectural program counter.

Function
- REQ-014 SHALL use one unified memory port shared by fetch, load and store; no internal memory.
- REQ-015 SHALL implement FSM states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, HALT.
- REQ-016 FETCH: drive MemReq=1, MemWE=0, MemAdr=PC; hold until MemReady; then IR<=MemRData, OldPC<=PC, PC<=PC+4, go to DECODE.
- REQ-017 DECODE: read rs1/rs2 into A/B; ALUOut<=OldPC+ImmExt (B/J immediate); dispatch by opcode: lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, branch->BRANCH, jal->JAL, else->HALT.
- REQ-018 MEMADR: ALUOut<=A+ImmExt (I or S immediate); lw->MEMREAD, sw->MEMWRITE.
- REQ-019 MEMREAD: MemReq=1, MemAdr=ALUOut; hold until MemReady; Data<=MemRData; go to MEMWB.
- REQ-020 MEMWB: rd<=Data, Retired=1, go to FETCH.
- REQ-021 MEMWRITE: MemReq=1, MemWE=1, MemAdr=ALUOut, MemWData=B; on MemReady Retired=1, go to FETCH.
- REQ-022 EXECR/EXECI: ALUOut<=A op B (or A op ImmExt); go to ALUWB; ALUWB writes rd, Retired=1, go to FETCH.
- REQ-023 ALU ops SHALL be add, sub, and, or, slt (signed): R-type add/sub/and/or/slt, I-type addi/andi/ori/slti; other funct3/funct7 combinations go to HALT.
- REQ-024 BRANCH: compute A-B; beq taken on zero, bne on non-zero, blt on signed less-than; if taken PC<=ALUOut; Retired=1; go to FETCH.
- REQ-025 JAL: rd<=PC (OldPC+4), PC<=ALUOut, Retired=1, go to FETCH.
- REQ-026 Register x0 SHALL read zero; writes to x0 SHALL be discarded.
- REQ-027 With NREGS=16, any rs1/rs2/rd index >=16 SHALL go to HALT.
- REQ-028 HALT: Illegal=1, MemReq=0, PC frozen at the faulting instruction's PC+4; remain until reset.
- REQ-029 Zero-wait latency SHALL be lw 5, sw 4, R/I 4, branch 3, jal 3 cycles; each MemReady-low cycle adds one.
- REQ-030 MemAdr/MemWE/MemWData SHALL stay stable while MemReq=1 and MemReady=0.
- REQ-031 Address arithmetic SHALL be modulo 2^32 (PC+4 at 32'hFFFF_FFFC wraps to 0); misaligned addresses pass through unchecked.

Reset
- REQ-032 On reset: state=FETCH, PC=RESET_PC, MemReq=0 in the reset cycle, Retired=0, Illegal=0, register file cleared to zero.
- REQ-033 Reset asserted mid-instruction (including during a pending memory wait) SHALL abandon it with no register or memory write in that cycle.

Verification
- V1: RESET_PC=0x100, MemReady tied high, addi x1,x0,5 -> fetch at 0x100, Retired on cycle 4, x1=5, PC=0x104.
- V2: sw x1,8(x0) then lw x2,8(x0) with MemReady low 2 cycles per access -> write at 0x8 data 5; x2=5; latencies 6 and 7 cycles.
- V3: x1=x2=3, beq x1,x2,+16 at 0x20 -> PC=0x30 after 3 cycles; bne same operands -> PC=0x24.
- V4: blt x1,x2 with x1=-1, x2=1 -> taken; jal x5,-8 at 0x40 -> x5=0x44, PC=0x38.
- V5: addi x0,x0,7 -> x0 reads 0; opcode 7'b1111111 -> Illegal=1, MemReq=0 forever, PC=faulting PC+4.
- V6: reset asserted in MEMREAD wait -> next cycle FETCH at RESET_PC, destination register unchanged.
